// File: rtl/holes_pkg.sv
// Shared definitions for the hole pocket detector.
// Holds the hole count, the per-hole overlap counter width, the hole index
// type and the confirmation FSM state encoding.
package holes_pkg;

  localparam int NUM_HOLES = 6;
  localparam int CNT_W     = 8;

  typedef logic [2:0]       hole_idx_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONFIRM = 2'd1,
    REPORT  = 2'd2
  } state_t;

endpackage

// File: rtl/hole_overlap_counter.sv
// Saturating ball/hole overlap pixel counter for one hole.
// Ports:
//   clk    - pixel clock
//   reset  - synchronous active-high reset
//   clear  - synchronous clear (frame start), wins over inc
//   inc    - count the current pixel
//   count  - overlapping pixels seen so far in this frame, sticks at max
module hole_overlap_counter
  import holes_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output cnt_t count
);

  cnt_t count_r;

  // Overlap count register: clear at frame start, saturate at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      count_r <= {CNT_W{1'b0}};
    end else if (inc && (count_r != {CNT_W{1'b1}})) begin
      count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/hole_pocket_detector.sv
// Detects a ball being pocketed: counts ball/hole overlap pixels per hole
// each frame, picks the most-overlapped hole at each frame start, and reports
// a pocket once the same hole has won CONFIRM_FRAMES consecutive frames.
// Ports:
//   clk                 - pixel clock
//   reset               - synchronous active-high reset
//   startOfFrame        - first pixel of a frame (evaluation point)
//   ballDrawingRequest  - ball covers the current pixel
//   holesDrawingRequest - per-hole coverage of the current pixel (bit0=A)
//   pocketAck           - consumer takes the pending pocket event
//   pocketValid         - pocket event pending
//   pocketHole          - pocketed hole index, 0 when no event pending
//   frameOverlap        - per-hole "any overlap" flag of the last full frame
module hole_pocket_detector
  import holes_pkg::*;
#(
  parameter int OVERLAP_TH     = 16,
  parameter int CONFIRM_FRAMES = 2
)
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 startOfFrame,
  input  logic                 ballDrawingRequest,
  input  logic [NUM_HOLES-1:0] holesDrawingRequest,
  input  logic                 pocketAck,
  output logic                 pocketValid,
  output hole_idx_t            pocketHole,
  output logic [NUM_HOLES-1:0] frameOverlap
);

  cnt_t                 count_s [NUM_HOLES];
  logic [NUM_HOLES-1:0] overlap_now_s;
  logic                 win_valid_s;
  hole_idx_t            win_hole_s;
  cnt_t                 best_s;

  state_t               state_r, state_next_s;
  hole_idx_t            cand_r, cand_next_s;
  logic [3:0]           frame_cnt_r, frame_cnt_next_s, frame_cnt_inc_s;
  logic                 pocket_valid_r;
  hole_idx_t            pocket_hole_r;
  logic [NUM_HOLES-1:0] frame_overlap_r;

  // The start-of-frame pixel belongs to no frame, so it is never counted.
  for (genvar gi = 0; gi < NUM_HOLES; gi++) begin : g_cnt
    hole_overlap_counter u_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (startOfFrame),
      .inc   (ballDrawingRequest && holesDrawingRequest[gi] && !startOfFrame),
      .count (count_s[gi])
    );
  end

  // Arbitration: strictly-greater keeps the lowest index on ties.
  always_comb begin
    win_valid_s   = 1'b0;
    win_hole_s    = 3'd0;
    best_s        = {CNT_W{1'b0}};
    overlap_now_s = {NUM_HOLES{1'b0}};
    for (int i = 0; i < NUM_HOLES; i++) begin
      overlap_now_s[i] = (count_s[i] != {CNT_W{1'b0}});
      if ((32'(count_s[i]) >= OVERLAP_TH) && (!win_valid_s || (count_s[i] > best_s))) begin
        win_valid_s = 1'b1;
        win_hole_s  = hole_idx_t'(i);
        best_s      = count_s[i];
      end else begin
        best_s      = best_s;
      end
    end
  end

  // Confirmation FSM next-state; REPORT only listens to pocketAck, which
  // also makes an ack coinciding with startOfFrame discard that evaluation.
  always_comb begin
    state_next_s     = state_r;
    cand_next_s      = cand_r;
    frame_cnt_next_s = frame_cnt_r;
    frame_cnt_inc_s  = frame_cnt_r + 4'd1;
    case (state_r)
      IDLE: begin
        if (startOfFrame && win_valid_s) begin
          cand_next_s      = win_hole_s;
          frame_cnt_next_s = 4'd1;
          state_next_s     = (CONFIRM_FRAMES == 32'sd1) ? REPORT : CONFIRM;
        end else begin
          state_next_s     = IDLE;
        end
      end
      CONFIRM: begin
        if (!startOfFrame) begin
          state_next_s = CONFIRM;
        end else if (!win_valid_s) begin
          state_next_s = IDLE;
        end else if (win_hole_s == cand_r) begin
          frame_cnt_next_s = frame_cnt_inc_s;
          state_next_s     = (frame_cnt_inc_s == 4'(CONFIRM_FRAMES)) ? REPORT : CONFIRM;
        end else begin
          cand_next_s      = win_hole_s;
          frame_cnt_next_s = 4'd1;
          state_next_s     = CONFIRM;
        end
      end
      REPORT: begin
        if (pocketAck) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = REPORT;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, outputs and overlap flags; outputs are registered from next state
  // so pocketValid rises the cycle after the confirming startOfFrame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= IDLE;
      cand_r          <= 3'd0;
      frame_cnt_r     <= 4'd0;
      pocket_valid_r  <= 1'b0;
      pocket_hole_r   <= 3'd0;
      frame_overlap_r <= {NUM_HOLES{1'b0}};
    end else begin
      state_r         <= state_next_s;
      cand_r          <= cand_next_s;
      frame_cnt_r     <= frame_cnt_next_s;
      pocket_valid_r  <= (state_next_s == REPORT);
      pocket_hole_r   <= (state_next_s == REPORT) ? cand_next_s : 3'd0;
      if (startOfFrame) begin
        frame_overlap_r <= overlap_now_s;
      end else begin
        frame_overlap_r <= frame_overlap_r;
      end
    end
  end

  assign pocketValid  = pocket_valid_r;
  assign pocketHole   = pocket_hole_r;
  assign frameOverlap = frame_overlap_r;

endmodule

// File: tb/tb_hole_pocket_detector.sv
// Directed scoreboard bench for hole_pocket_detector (default parameters).
module tb_hole_pocket_detector;

  logic       clk = 1'b0;
  logic       reset;
  logic       startOfFrame;
  logic       ballDrawingRequest;
  logic [5:0] holesDrawingRequest;
  logic       pocketAck;
  logic       pocketValid;
  logic [2:0] pocketHole;
  logic [5:0] frameOverlap;

  localparam logic [5:0] H_A = 6'b000001;
  localparam logic [5:0] H_B = 6'b000010;
  localparam logic [5:0] H_C = 6'b000100;
  localparam logic [5:0] H_D = 6'b001000;
  localparam logic [5:0] H_E = 6'b010000;
  localparam logic [5:0] H_F = 6'b100000;
  localparam logic [5:0] H_0 = 6'b000000;

  typedef struct packed {
    logic       v;
    logic [2:0] h;
    logic [5:0] ov;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hole_pocket_detector dut (
    .clk                 (clk),
    .reset               (reset),
    .startOfFrame        (startOfFrame),
    .ballDrawingRequest  (ballDrawingRequest),
    .holesDrawingRequest (holesDrawingRequest),
    .pocketAck           (pocketAck),
    .pocketValid         (pocketValid),
    .pocketHole          (pocketHole),
    .frameOverlap        (frameOverlap)
  );

  task automatic check_out(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      checks++;
      assert (pocketValid === e.v) else begin
        errors++;
        $error("FAIL %s pocketValid got %0b expected %0b", tag, pocketValid, e.v);
      end
      checks++;
      assert (pocketHole === e.h) else begin
        errors++;
        $error("FAIL %s pocketHole got %0d expected %0d", tag, pocketHole, e.h);
      end
      checks++;
      assert (frameOverlap === e.ov) else begin
        errors++;
        $error("FAIL %s frameOverlap got %b expected %b", tag, frameOverlap, e.ov);
      end
    end
  endtask

  // One clock with the given inputs; the expectation is queued at drive time
  // and compared against the outputs #1 after the edge.
  task automatic step(input string tag, input logic s, input logic a, input logic r,
                      input logic b, input logic [5:0] m,
                      input logic ev, input logic [2:0] eh, input logic [5:0] eov);
    exp_q.push_back(exp_t'{v: ev, h: eh, ov: eov});
    startOfFrame        = s;
    pocketAck           = a;
    reset               = r;
    ballDrawingRequest  = b;
    holesDrawingRequest = m;
    @(posedge clk);
    #1;
    startOfFrame        = 1'b0;
    pocketAck           = 1'b0;
    reset               = 1'b0;
    ballDrawingRequest  = 1'b0;
    holesDrawingRequest = H_0;
    check_out(tag);
  endtask

  task automatic sof(input string tag, input logic ev, input logic [2:0] eh,
                     input logic [5:0] eov);
    step(tag, 1'b1, 1'b0, 1'b0, 1'b0, H_0, ev, eh, eov);
  endtask

  task automatic pixels(input logic [5:0] m, input int n);
    for (int i = 0; i < n; i++) begin
      ballDrawingRequest  = 1'b1;
      holesDrawingRequest = m;
      @(posedge clk);
      #1;
    end
    ballDrawingRequest  = 1'b0;
    holesDrawingRequest = H_0;
  endtask

  initial begin
    reset               = 1'b1;
    startOfFrame        = 1'b0;
    ballDrawingRequest  = 1'b0;
    holesDrawingRequest = H_0;
    pocketAck           = 1'b0;
    @(posedge clk);
    #1;
    // Reset wins over a pixel, startOfFrame and ack in the same cycle.
    step("reset", 1'b1, 1'b1, 1'b1, 1'b1, 6'b111111, 1'b0, 3'd0, H_0);

    // HoleC 20 px for two frames, then a held report and ack.
    sof("c_f1", 1'b0, 3'd0, H_0);
    pixels(H_C, 20);
    sof("c_f2", 1'b0, 3'd0, H_C);
    pixels(H_C, 20);
    sof("c_f3", 1'b1, 3'd2, H_C);
    pixels(H_B, 30);
    sof("c_hold", 1'b1, 3'd2, H_B);
    step("c_ack", 1'b0, 1'b1, 1'b0, 1'b0, H_0, 1'b0, 3'd0, H_B);

    // HoleA 10 px is below threshold for five frames.
    sof("a_start", 1'b0, 3'd0, H_0);
    for (int f = 0; f < 5; f++) begin
      pixels(H_A, 10);
      sof("a_low", 1'b0, 3'd0, H_A);
    end

    // Candidate switches from B to E, E then confirms.
    pixels(H_B, 30);
    sof("be_f1", 1'b0, 3'd0, H_B);
    pixels(H_E, 30);
    sof("be_f2", 1'b0, 3'd0, H_E);
    pixels(H_E, 30);
    sof("be_f3", 1'b1, 3'd4, H_E);
    step("be_ack", 1'b0, 1'b1, 1'b0, 1'b0, H_0, 1'b0, 3'd0, H_E);

    // A/D tie resolves to A; ack with startOfFrame discards the C frame.
    pixels(H_A | H_D, 40);
    sof("tie_f1", 1'b0, 3'd0, H_A | H_D);
    pixels(H_A | H_D, 40);
    sof("tie_f2", 1'b1, 3'd0, H_A | H_D);
    pixels(H_C, 20);
    step("sof_ack", 1'b1, 1'b1, 1'b0, 1'b0, H_0, 1'b0, 3'd0, H_C);
    pixels(H_C, 20);
    sof("after_discard", 1'b0, 3'd0, H_C);
    sof("no_winner", 1'b0, 3'd0, H_0);

    // C reaches 300 px (saturates at 255) against D at 100 px.
    pixels(H_C | H_D, 100);
    pixels(H_C, 200);
    sof("sat_f1", 1'b0, 3'd0, H_C | H_D);
    pixels(H_C | H_D, 100);
    pixels(H_C, 200);
    sof("sat_f2", 1'b1, 3'd2, H_C | H_D);
    step("sat_ack", 1'b0, 1'b1, 1'b0, 1'b0, H_0, 1'b0, 3'd0, H_C | H_D);

    // Reset while reporting, mid-frame; only post-reset pixels count.
    pixels(H_E, 20);
    sof("rst_f1", 1'b0, 3'd0, H_E);
    pixels(H_E, 20);
    sof("rst_f2", 1'b1, 3'd4, H_E);
    pixels(H_F, 20);
    step("rst_report", 1'b0, 1'b0, 1'b1, 1'b1, H_F, 1'b0, 3'd0, H_0);
    pixels(H_F, 5);
    sof("rst_post", 1'b0, 3'd0, H_F);
    pixels(H_E, 20);
    sof("rst_fresh", 1'b0, 3'd0, H_E);
    sof("rst_idle", 1'b0, 3'd0, H_0);
    step("ack_idle", 1'b0, 1'b1, 1'b0, 1'b0, H_0, 1'b0, 3'd0, H_0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hole_pocket_detector.md
HOLE_POCKET_DETECTOR -- requirements
Module: hole_pocket_detector

Interface
REQ-001 Parameter OVERLAP_TH, default 16: minimum ball/hole overlapping pixels in one frame for a hole to count as hit.
REQ-002 Parameter CONFIRM_FRAMES, default 2, legal 1..15: consecutive frames the same hole must be hit before a pocket is reported.
REQ-003 clk  in  1  pixel clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 startOfFrame  in  1  one-cycle pulse marking the first pixel of a frame.
REQ-006 ballDrawingRequest  in  1  ball object requests the current pixel.
REQ-007 holesDrawingRequest  in  6  per-hole drawing request; bit0=holeA ... bit5=holeF.
REQ-008 pocketAck  in  1  game controller consumes the pending pocket event.
REQ-009 pocketValid  out  1  a confirmed pocket event is pending.
REQ-010 pocketHole  out  3  index 0..5 of the pocketed hole; meaningful only while pocketValid=1.
REQ-011 frameOverlap  out  6  per-hole flag: at least one overlapping pixel in the last completed frame.

Function
REQ-012 Per hole i, an 8-bit counter SHALL increment in each cycle with ballDrawingRequest && holesDrawingRequest[i] && !startOfFrame, saturating at 255.
REQ-013 On startOfFrame all six counters SHALL clear to 0; the pixel in that cycle is not counted.
REQ-014 On startOfFrame the counts of the ending frame SHALL be evaluated: winner = hole with count >= OVERLAP_TH and highest count; ties go to the lowest index; no such hole = no winner.
REQ-015 On startOfFrame frameOverlap[i] SHALL load (count[i] != 0); it holds between frames.
REQ-016 FSM states: IDLE, CONFIRM, REPORT; a 4-bit frame counter frameCnt and a 3-bit candHole are kept.
REQ-017 IDLE: on evaluation with a winner -> candHole=winner, frameCnt=1; go REPORT if CONFIRM_FRAMES==1, else CONFIRM.
REQ-018 CONFIRM: on evaluation with winner==candHole -> frameCnt+1; go REPORT when it reaches CONFIRM_FRAMES.
REQ-019 CONFIRM: on evaluation with a different winner -> candHole=new winner, frameCnt=1, stay CONFIRM; with no winner -> IDLE.
REQ-020 REPORT: pocketValid=1 and pocketHole=candHole, both stable until the cycle after pocketAck=1; then -> IDLE with pocketValid=0.
REQ-021 In REPORT, frame evaluations SHALL NOT change FSM state or candHole; counters and frameOverlap keep operating.
REQ-022 pocketAck outside REPORT SHALL be ignored.
REQ-023 startOfFrame and pocketAck in the same REPORT cycle: ack wins, FSM -> IDLE, that frame's evaluation discarded.
REQ-024 Latency: pocketValid rises one cycle after the startOfFrame completing confirmation.
REQ-025 pocketHole SHALL read 0 whenever pocketValid=0.

Reset
REQ-026 With reset=1 at a clock edge: counters=0, frameCnt=0, candHole=0, FSM=IDLE, pocketValid=0, pocketHole=0, frameOverlap=0.
REQ-027 Reset mid-frame or in REPORT SHALL drop any pending event; the next evaluation sees only pixels after reset release.
REQ-028 Reset SHALL take priority over all other inputs in the same cycle.

Structure
REQ-029 Package holes_pkg SHALL hold NUM_HOLES=6, hole index typedef (3 bit), FSM state enum, counter width 8.
REQ-030 One sub-module hole_overlap_counter (saturating counter with clear, one per hole via generate); arbitration and FSM in the top.

Verification
REQ-031 Ball overlaps holeC 20 px in frames 1 and 2, ack at frame 3 -> pocketValid=1, pocketHole=2 one cycle after frame-3 startOfFrame; low one cycle after ack.
REQ-032 Overlap holeA 10 px (below 16) for 5 frames -> pocketValid stays 0, frameOverlap[0]=1 each frame.
REQ-033 Frame 1 holeB 30 px, frame 2 holeE 30 px, frame 3 holeE 30 px -> pocketHole=4 after frame-4 startOfFrame.
REQ-034 holeA and holeD each 40 px in two frames -> pocketHole=0 (tie to lowest index).
REQ-035 Overlap 300 px in one frame -> counter saturates 255, no wrap, winner still valid.
REQ-036 Reset asserted while in REPORT -> pocketValid=0 next cycle; startOfFrame with pocketAck in REPORT -> IDLE, no new event.
